stack_ctrl: RTL and testbench
=============================

STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 SHALL have parameter N, default 16, data width of the stack it drives.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port op_valid  input  1  opcode offered this cycle.
REQ-005 SHALL have port op  input  3  opcode: 0 NOP, 1 PUSHI, 2 POP, 3 DUP, 4 ADD, 5 SUB, 6 AND, 7 illegal.
REQ-006 SHALL have port imm  input  N  immediate for PUSHI, sampled with op.
REQ-007 SHALL have port op_ready  output  1  controller can accept an opcode.
REQ-008 SHALL have ports qtop, qnext  input  N each  top and second entries of the driven 4-entry stack.
REQ-009 SHALL have ports load, push, pop  output  1 each  stack control strobes.
REQ-010 SHALL have port d  output  N  data to stack top.
REQ-011 SHALL have port depth  output  3  valid entries, 0..4.
REQ-012 SHALL have ports err (output, 1) and err_code (output, 2)  sticky error flag and cause: 01 overflow, 10 underflow, 11 illegal opcode.

Function
REQ-013 SHALL implement FSM states IDLE, EXEC, ERR; op_ready = 1 only in IDLE.
REQ-014 SHALL accept an opcode when op_valid && op_ready; opcode and imm registered at that edge.
REQ-015 SHALL, on a legal accept, go IDLE->EXEC, drive strobes for exactly the one EXEC cycle, return to IDLE next edge; throughput one op per 2 cycles.
REQ-016 SHALL drive strobes in EXEC: PUSHI load=1 push=1 d=imm; POP pop=1; DUP push=1; ADD/SUB/AND load=1 pop=1; NOP none.
REQ-017 SHALL compute d in EXEC from live qtop/qnext: ADD qnext+qtop, SUB qnext-qtop, AND qnext&qtop, all modulo 2^N, carry discarded.
REQ-018 SHALL hold load, push, pop = 0 and d = 0 in IDLE, ERR, and for NOP.
REQ-019 SHALL update depth at end of EXEC: PUSHI/DUP +1; POP/ADD/SUB/AND -1; NOP 0.
REQ-020 SHALL check legality at accept using current depth: PUSHI/DUP need depth<4; POP/DUP need depth>=1; ADD/SUB/AND need depth>=2.
REQ-021 SHALL, on an illegal accept, go IDLE->ERR, set err=1 and err_code, emit no strobes, leave depth unchanged.
REQ-022 SHALL give overflow priority over underflow; opcode 7 always yields 11.
REQ-023 SHALL remain in ERR (op_ready=0, err held) until rst_n asserted.
REQ-024 SHALL ignore op_valid when op_ready=0; no buffering of offered opcodes.

Reset
REQ-025 SHALL, while rst_n=0, immediately force state IDLE, depth 0, err 0, err_code 00, load/push/pop 0, d 0.
REQ-026 SHALL drop an in-flight EXEC on reset with no strobe surviving past rst_n falling.
REQ-027 SHALL assert op_ready in the first cycle after rst_n deasserts.

Structure
REQ-028 SHALL take opcode encodings, err_code values and FSM state encoding from shared package stack_pkg.
REQ-029 SHALL place ADD/SUB/AND datapath in one combinational sub-module stack_alu (parameter N).

Verification (N=16, bench includes 4-entry stack model)
REQ-030 SHALL cover: PUSHI 0x0003, PUSHI 0x0005, ADD -> EXEC of ADD shows load=1 pop=1 d=0x0008; depth 1,2,1; qtop 0x0008.
REQ-031 SHALL cover: PUSHI 0x0000, PUSHI 0x0001, SUB -> d=0xFFFF; depth 1; DUP -> push=1 only, depth 2, qnext 0xFFFF.
REQ-032 SHALL cover: five PUSHI 0x0001 -> fifth makes no strobe, err=1, err_code=01, depth 4, op_ready 0 held 10 cycles.
REQ-033 SHALL cover: after reset, POP -> err_code=10, depth 0; separately op=7 at depth 2 -> err_code=11.
REQ-034 SHALL cover: rst_n low mid-EXEC of PUSHI -> load/push fall same cycle, depth 0, op_ready 1 after release.
REQ-035 SHALL cover: op_valid held high continuously -> ops accepted every second cycle, never in EXEC.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared opcode, error-cause and FSM encodings for the stack controller,
// plus the legality check applied when an opcode is accepted.
package stack_pkg;

    localparam int STACK_DEPTH = 4;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_PUSHI = 3'd1,
        OP_POP   = 3'd2,
        OP_DUP   = 3'd3,
        OP_ADD   = 3'd4,
        OP_SUB   = 3'd5,
        OP_AND   = 3'd6,
        OP_ILL   = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_OVF  = 2'b01,
        ERR_UNF  = 2'b10,
        ERR_ILL  = 2'b11
    } err_code_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_ERR  = 2'd2
    } state_e;

    // Overflow is tested before underflow so DUP on a full stack reports overflow.
    function automatic err_code_e check_op(input opcode_e op, input logic [2:0] depth);
        logic full;
        logic has1;
        logic has2;
        full = (depth >= 3'(STACK_DEPTH));
        has1 = (depth >= 3'd1);
        has2 = (depth >= 3'd2);
        case (op)
            OP_PUSHI:               check_op = full ? ERR_OVF : ERR_NONE;
            OP_DUP:                 check_op = full ? ERR_OVF : (!has1 ? ERR_UNF : ERR_NONE);
            OP_POP:                 check_op = !has1 ? ERR_UNF : ERR_NONE;
            OP_ADD, OP_SUB, OP_AND: check_op = !has2 ? ERR_UNF : ERR_NONE;
            OP_ILL:                 check_op = ERR_ILL;
            default:                check_op = ERR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/stack_alu.sv
// Combinational two-operand datapath for ADD/SUB/AND on the top two stack entries.
module stack_alu
    import stack_pkg::*;
#(
    parameter int N = 16
) (
    input  logic [2:0]   op,
    input  logic [N-1:0] qtop,
    input  logic [N-1:0] qnext,
    output logic [N-1:0] res
);

    // Operand order is second-entry OP top, results wrap modulo 2^N.
    always_comb begin
        res = '0;
        case (opcode_e'(op))
            OP_ADD:  res = qnext + qtop;
            OP_SUB:  res = qnext - qtop;
            OP_AND:  res = qnext & qtop;
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/stack_ctrl.sv
// Opcode-driven controller for an external 4-entry stack: one op per two
// cycles, strobes only in EXEC, sticky error state until reset.
module stack_ctrl
    import stack_pkg::*;
#(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         op_valid,
    input  logic [2:0]   op,
    input  logic [N-1:0] imm,
    output logic         op_ready,
    input  logic [N-1:0] qtop,
    input  logic [N-1:0] qnext,
    output logic         load,
    output logic         push,
    output logic         pop,
    output logic [N-1:0] d,
    output logic [2:0]   depth,
    output logic         err,
    output logic [1:0]   err_code,
    output logic [1:0]   state_dbg
);

    // Handshake: an opcode (with imm) transfers on a rising edge where
    // op_valid && op_ready. op_ready depends only on state, never on op_valid,
    // and an offer made while op_ready is low is dropped, not buffered.

    state_e    state_q, state_d;
    opcode_e   op_q;
    logic [N-1:0] imm_q;
    logic [2:0]   depth_q, depth_d;
    logic         err_q;
    err_code_e    code_q;
    err_code_e    acc_code;
    logic         accept;
    logic [N-1:0] alu_res;

    stack_alu #(.N(N)) u_alu (
        .op    (op_q),
        .qtop  (qtop),
        .qnext (qnext),
        .res   (alu_res)
    );

    assign accept   = op_valid && (state_q == S_IDLE);
    assign acc_code = check_op(opcode_e'(op), depth_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= OP_NOP;
            imm_q   <= '0;
            depth_q <= 3'd0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            depth_q <= depth_d;
            if (accept) begin
                if (acc_code == ERR_NONE) begin
                    op_q  <= opcode_e'(op);
                    imm_q <= imm;
                end else begin
                    err_q  <= 1'b1;
                    code_q <= acc_code;
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        depth_d  = depth_q;
        op_ready = 1'b0;
        load     = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        d        = '0;
        case (state_q)
            S_IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    state_d = (acc_code == ERR_NONE) ? S_EXEC : S_ERR;
                end
            end
            S_EXEC: begin
                state_d = S_IDLE;
                case (op_q)
                    OP_PUSHI: begin
                        load    = 1'b1;
                        push    = 1'b1;
                        d       = imm_q;
                        depth_d = depth_q + 3'd1;
                    end
                    OP_POP: begin
                        pop     = 1'b1;
                        depth_d = depth_q - 3'd1;
                    end
                    OP_DUP: begin
                        push    = 1'b1;
                        depth_d = depth_q + 3'd1;
                    end
                    OP_ADD, OP_SUB, OP_AND: begin
                        load    = 1'b1;
                        pop     = 1'b1;
                        d       = alu_res;
                        depth_d = depth_q - 3'd1;
                    end
                    default: begin
                        depth_d = depth_q;
                    end
                endcase
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign depth     = depth_q;
    assign err       = err_q;
    assign err_code  = code_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: 4-entry stack model on the strobes, queue-based
// reference model, expected-response queue checked by an independent monitor.
module tb_stack_ctrl;
  import stack_pkg::*;

  typedef struct packed {
    logic        is_err;
    logic        load;
    logic        push;
    logic        pop;
    logic [15:0] d;
    logic [2:0]  depth_after;
    logic [1:0]  code;
    logic [15:0] top_after;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        op_valid;
  logic [2:0]  op_in;
  logic [15:0] imm_in;
  logic        op_ready;
  logic [15:0] qtop, qnext;
  logic        load, push, pop;
  logic [15:0] d;
  logic [2:0]  depth;
  logic        err;
  logic [1:0]  err_code;
  logic [1:0]  state_dbg;

  exp_t        exp_q[$];
  logic [15:0] ref_stk[$];
  logic        ref_err;
  int          tests_run = 0;
  int          tests_failed = 0;
  logic [15:0] phys[4];

  stack_ctrl #(.N(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op_valid  (op_valid),
    .op        (op_in),
    .imm       (imm_in),
    .op_ready  (op_ready),
    .qtop      (qtop),
    .qnext     (qnext),
    .load      (load),
    .push      (push),
    .pop       (pop),
    .d         (d),
    .depth     (depth),
    .err       (err),
    .err_code  (err_code),
    .state_dbg (state_dbg)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // 4-entry stack driven by the controller strobes
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) phys[i] <= 16'h0;
    end else if (push) begin
      phys[3] <= phys[2];
      phys[2] <= phys[1];
      phys[1] <= phys[0];
      phys[0] <= load ? d : phys[0];
    end else if (pop) begin
      phys[0] <= load ? d : phys[1];
      phys[1] <= phys[2];
      phys[2] <= phys[3];
      phys[3] <= 16'h0;
    end
  end
  assign qtop  = phys[0];
  assign qnext = phys[1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: stack as a queue, index 0 is the top
  function automatic exp_t model_accept(input logic [2:0] o, input logic [15:0] v);
    exp_t r;
    int sz;
    logic [1:0] code;
    logic [15:0] a, b, res;
    r = '0;
    sz = ref_stk.size();
    if (o == 3'd7) code = 2'b11;
    else if ((o == 3'd1 || o == 3'd3) && sz == 4) code = 2'b01;
    else if (((o == 3'd2 || o == 3'd3) && sz < 1) || (o >= 3'd4 && o <= 3'd6 && sz < 2)) code = 2'b10;
    else code = 2'b00;
    if (code != 2'b00) begin
      r.is_err = 1'b1;
      r.code = code;
      r.depth_after = 3'(sz);
      ref_err = 1'b1;
      return r;
    end
    case (o)
      3'd1: begin
        ref_stk.push_front(v);
        r.load = 1'b1; r.push = 1'b1; r.d = v;
      end
      3'd2: begin
        void'(ref_stk.pop_front());
        r.pop = 1'b1;
      end
      3'd3: begin
        a = ref_stk[0];
        ref_stk.push_front(a);
        r.push = 1'b1;
      end
      3'd4, 3'd5, 3'd6: begin
        a = ref_stk.pop_front();
        b = ref_stk.pop_front();
        if (o == 3'd4) res = b + a;
        else if (o == 3'd5) res = b - a;
        else res = b & a;
        ref_stk.push_front(res);
        r.load = 1'b1; r.pop = 1'b1; r.d = res;
      end
      default: ;
    endcase
    r.depth_after = 3'(ref_stk.size());
    r.top_after = (ref_stk.size() > 0) ? ref_stk[0] : 16'h0;
    return r;
  endfunction

  // driver tasks
  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!op_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!op_ready) chk("op_ready_timeout", 32'(op_ready), 32'd1);
  endtask

  task automatic do_op(input logic [2:0] o, input logic [15:0] v);
    exp_t r;
    wait_ready();
    if (!op_ready) return;
    op_valid = 1'b1;
    op_in = o;
    imm_in = v;
    @(posedge clk);
    r = model_accept(o, v);
    exp_q.push_back(r);
    #1;
    op_valid = 1'b0;
    op_in = 3'($urandom);
    imm_in = 16'($urandom);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    op_valid = 1'b0;
    ref_stk.delete();
    ref_err = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_load", 32'(load), 32'd0);
    chk("rst_push", 32'(push), 32'd0);
    chk("rst_pop", 32'(pop), 32'd0);
    chk("rst_d", 32'(d), 32'd0);
    chk("rst_depth", 32'(depth), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_reset", 32'(op_ready), 32'd1);
  endtask

  task automatic hold_valid(input int ncyc);
    exp_t r;
    logic idle_m;
    wait_ready();
    op_valid = 1'b1;
    op_in = 3'd0;
    idle_m = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk);
      if (idle_m) begin
        r = model_accept(3'd0, 16'h0);
        exp_q.push_back(r);
      end
      idle_m = !idle_m;
      @(negedge clk);
      chk("hold_ready", 32'(op_ready), 32'(idle_m));
    end
    op_valid = 1'b0;
  endtask

  // scoreboard monitor
  initial begin : monitor
    exp_t r;
    logic err_prev;
    err_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        err_prev = 1'b0;
        continue;
      end
      if (state_dbg == S_EXEC) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_exec", 32'(exp_q.size()), 32'd1);
        end else begin
          r = exp_q.pop_front();
          chk("exec_kind", 32'(r.is_err), 32'd0);
          chk("exec_load", 32'(load), 32'(r.load));
          chk("exec_push", 32'(push), 32'(r.push));
          chk("exec_pop", 32'(pop), 32'(r.pop));
          chk("exec_d", 32'(d), 32'(r.d));
          @(negedge clk);
          if (rst_n) begin
            chk("depth_after", 32'(depth), 32'(r.depth_after));
            if (r.depth_after != 3'd0) chk("qtop_after", 32'(qtop), 32'(r.top_after));
          end
        end
      end else if (err && !err_prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_err", 32'(exp_q.size()), 32'd1);
        end else begin
          r = exp_q.pop_front();
          chk("err_kind", 32'(r.is_err), 32'd1);
          chk("err_code", 32'(err_code), 32'(r.code));
          chk("err_depth", 32'(depth), 32'(r.depth_after));
          chk("err_strobes", 32'({load, push, pop}), 32'd0);
        end
      end
      err_prev = err;
    end
  end

  // stimulus
  initial begin : main
    logic [2:0] pick;
    int sel;
    op_valid = 1'b0;
    op_in = 3'd0;
    imm_in = 16'h0;
    ref_err = 1'b0;
    apply_reset();

    // PUSHI 3, PUSHI 5, ADD
    do_op(3'd1, 16'h0003);
    repeat (2) @(negedge clk);
    chk("add_depth1", 32'(depth), 32'd1);
    do_op(3'd1, 16'h0005);
    repeat (2) @(negedge clk);
    chk("add_depth2", 32'(depth), 32'd2);
    do_op(3'd4, 16'h0);
    @(negedge clk);
    chk("add_load", 32'(load), 32'd1);
    chk("add_pop", 32'(pop), 32'd1);
    chk("add_d", 32'(d), 32'h0008);
    @(negedge clk);
    chk("add_depth3", 32'(depth), 32'd1);
    chk("add_qtop", 32'(qtop), 32'h0008);

    // PUSHI 0, PUSHI 1, SUB, DUP
    apply_reset();
    do_op(3'd1, 16'h0000);
    do_op(3'd1, 16'h0001);
    do_op(3'd5, 16'h0);
    repeat (2) @(negedge clk);
    chk("sub_qtop", 32'(qtop), 32'hFFFF);
    chk("sub_depth", 32'(depth), 32'd1);
    do_op(3'd3, 16'h0);
    @(negedge clk);
    chk("dup_strobes", 32'({load, push, pop}), 32'b010);
    @(negedge clk);
    chk("dup_depth", 32'(depth), 32'd2);
    chk("dup_qnext", 32'(qnext), 32'hFFFF);

    // overflow on fifth PUSHI, then ERR held
    apply_reset();
    repeat (5) do_op(3'd1, 16'h0001);
    @(negedge clk);
    chk("ovf_strobes", 32'({load, push, pop}), 32'd0);
    chk("ovf_err", 32'(err), 32'd1);
    chk("ovf_code", 32'(err_code), 32'b01);
    chk("ovf_depth", 32'(depth), 32'd4);
    op_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      op_in = 3'($urandom_range(0, 6));
      @(negedge clk);
      chk("err_hold_ready", 32'(op_ready), 32'd0);
      chk("err_hold_err", 32'(err), 32'd1);
      chk("err_hold_depth", 32'(depth), 32'd4);
    end
    op_valid = 1'b0;

    // underflow from empty, illegal opcode at depth 2
    apply_reset();
    do_op(3'd2, 16'h0);
    @(negedge clk);
    chk("unf_code", 32'(err_code), 32'b10);
    chk("unf_depth", 32'(depth), 32'd0);
    apply_reset();
    do_op(3'd1, 16'($urandom));
    do_op(3'd1, 16'($urandom));
    do_op(3'd7, 16'h0);
    @(negedge clk);
    chk("ill_code", 32'(err_code), 32'b11);
    chk("ill_depth", 32'(depth), 32'd2);

    // reset in the middle of a PUSHI EXEC
    apply_reset();
    do_op(3'd1, 16'hA5A5);
    do_op(3'd1, 16'h1234);
    @(negedge clk);
    chk("mid_load", 32'(load), 32'd1);
    chk("mid_d", 32'(d), 32'h1234);
    #2;
    apply_reset();

    // op_valid held high continuously
    do_op(3'd1, 16'h0007);
    hold_valid(20);

    // randomized ops against the reference model
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      if (ref_err) begin
        repeat (2) @(negedge clk);
        apply_reset();
      end
      sel = $urandom_range(0, 19);
      if (sel <= 5) pick = 3'd1;
      else if (sel <= 8) pick = 3'd2;
      else if (sel <= 10) pick = 3'd3;
      else if (sel <= 12) pick = 3'd4;
      else if (sel <= 14) pick = 3'd5;
      else if (sel <= 16) pick = 3'd6;
      else if (sel <= 18) pick = 3'd0;
      else pick = 3'd7;
      do_op(pick, 16'($urandom));
    end

    repeat (4) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
